// File: rtl/coremem_arbiter_if.sv
// Shared-memory bus between fetch/LSU ports, arbiter and SRAM.
// Slave modport is the arbiter's view; master is the requester/SRAM side.
interface coremem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [DATA_WIDTH-1:0] instr_rdata_o;

  logic                  data_req_i;
  logic                  data_we_i;
  logic [BW-1:0]         data_be_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [DATA_WIDTH-1:0] data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [DATA_WIDTH-1:0] data_rdata_o;

  logic                  mem_ce_o;
  logic                  mem_we_o;
  logic [BW-1:0]         mem_be_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  logic [15:0]           conflict_cnt_o;

  modport slave (
    input  instr_req_i, instr_addr_i,
    input  data_req_i, data_we_i, data_be_i,
    input  data_addr_i, data_wdata_i,
    input  mem_rdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    output data_gnt_o, data_rvalid_o, data_rdata_o,
    output mem_ce_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wdata_o,
    output conflict_cnt_o
  );

  modport master (
    output instr_req_i, instr_addr_i,
    output data_req_i, data_we_i, data_be_i,
    output data_addr_i, data_wdata_i,
    output mem_rdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
    input  data_gnt_o, data_rvalid_o, data_rdata_o,
    input  mem_ce_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wdata_o,
    input  conflict_cnt_o
  );
endinterface

// File: rtl/coremem_arbiter.sv
// Fetch/LSU arbiter onto one single-port SRAM with alternating
// priority under contention and a one-cycle response pipeline.
module coremem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  coremem_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_INSTR_RSP = 2'b01,
    S_DATA_RSP  = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;

  logic        r_prio_d;
  logic        r_we;
  logic [15:0] r_cnt;

  logic w_both;
  logic w_gnt_i;
  logic w_gnt_d;

  logic                  w_ce;
  logic                  w_we;
  logic [BW-1:0]         w_be;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

  // grants are suppressed while reset is held, whatever the requests
  always_comb begin
    w_both  = bus.instr_req_i & bus.data_req_i;
    w_gnt_d = ~rst_i & bus.data_req_i
            & (~bus.instr_req_i | r_prio_d);
    w_gnt_i = ~rst_i & bus.instr_req_i
            & (~bus.data_req_i | ~r_prio_d);
  end

  always_comb begin
    w_ce    = 1'b0;
    w_we    = 1'b0;
    w_be    = '0;
    w_addr  = '0;
    w_wdata = '0;
    unique case (1'b1)
      w_gnt_i: begin
        w_ce   = 1'b1;
        w_be   = {BW{1'b1}};
        w_addr = bus.instr_addr_i;
      end
      w_gnt_d: begin
        w_ce    = 1'b1;
        w_we    = bus.data_we_i;
        w_be    = bus.data_be_i;
        w_addr  = bus.data_addr_i;
        w_wdata = bus.data_wdata_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.instr_gnt_o = w_gnt_i;
    bus.data_gnt_o  = w_gnt_d;
    bus.mem_ce_o    = w_ce;
    bus.mem_we_o    = w_we;
    bus.mem_be_o    = w_be;
    bus.mem_addr_o  = w_addr;
    bus.mem_wdata_o = w_wdata;
    bus.conflict_cnt_o = r_cnt;
  end

  always_comb begin
    w_next = S_IDLE;
    if (w_gnt_i)
      w_next = S_INSTR_RSP;
    else if (w_gnt_d)
      w_next = S_DATA_RSP;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_prio_d <= 1'b1;
      r_we     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_i)
        r_prio_d <= 1'b1;
      else if (w_gnt_d)
        r_prio_d <= 1'b0;
      if (w_gnt_d)
        r_we <= bus.data_we_i;
      if (w_both && r_cnt != 16'hFFFF)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  // an illegal state encoding falls to default: no rvalid, IDLE next
  always_comb begin
    bus.instr_rvalid_o = 1'b0;
    bus.instr_rdata_o  = '0;
    bus.data_rvalid_o  = 1'b0;
    bus.data_rdata_o   = '0;
    case (r_state)
      S_INSTR_RSP: begin
        bus.instr_rvalid_o = 1'b1;
        bus.instr_rdata_o  = bus.mem_rdata_i;
      end
      S_DATA_RSP: begin
        bus.data_rvalid_o = 1'b1;
        if (!r_we)
          bus.data_rdata_o = bus.mem_rdata_i;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_coremem_arbiter.sv
// Randomized bench for coremem_arbiter against a
// transaction-level model of grant, response and conflict count.
module tb_coremem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  coremem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  coremem_arbiter #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model: who wins a tie, what answers next cycle, count
  bit m_prio_d;
  int m_rsp;
  bit m_rsp_we;
  int m_cnt;
  int m_last;
  bit i_pend;
  bit d_pend;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input bit do_chk);
    bit bi, bd;
    int g;
    #1;
    if (rst) begin
      m_rsp = 0;
      m_prio_d = 1'b1;
      m_cnt = 0;
    end
    bi = bus.instr_req_i && !rst;
    bd = bus.data_req_i && !rst;
    g = 0;
    if (bi && bd) g = m_prio_d ? 2 : 1;
    else if (bi) g = 1;
    else if (bd) g = 2;
    if (do_chk) begin
      chk("ignt", bus.instr_gnt_o, g == 1);
      chk("dgnt", bus.data_gnt_o, g == 2);
      chk("ce", bus.mem_ce_o, g != 0);
      chk("we", bus.mem_we_o,
          (g == 2) ? bus.data_we_i : 1'b0);
      chk("be", bus.mem_be_o,
          (g == 1) ? 4'hF : (g == 2) ? bus.data_be_i : 4'h0);
      chk("addr", bus.mem_addr_o,
          (g == 1) ? bus.instr_addr_i :
          (g == 2) ? bus.data_addr_i : 16'h0);
      chk("wdata", bus.mem_wdata_o,
          (g == 2) ? bus.data_wdata_i : 32'h0);
      chk("irv", bus.instr_rvalid_o, m_rsp == 1);
      chk("ird", bus.instr_rdata_o,
          (m_rsp == 1) ? bus.mem_rdata_i : 32'h0);
      chk("drv", bus.data_rvalid_o, m_rsp == 2);
      chk("drd", bus.data_rdata_o,
          (m_rsp == 2 && !m_rsp_we) ? bus.mem_rdata_i : 32'h0);
      chk("cnt", bus.conflict_cnt_o, m_cnt);
    end
    @(posedge clk);
    if (!rst) begin
      if (bi && bd && m_cnt < 65535) m_cnt++;
      m_rsp = g;
      if (g == 2) m_rsp_we = bus.data_we_i;
      if (g == 1) m_prio_d = 1'b1;
      else if (g == 2) m_prio_d = 1'b0;
    end
    m_last = g;
    @(negedge clk);
  endtask

  task automatic rand_cycle(input bit force_both,
                            input bit do_chk);
    if (!i_pend && (force_both || $urandom_range(0, 1) == 1)) begin
      i_pend = 1'b1;
      bus.instr_addr_i = 16'($urandom);
    end
    if (!d_pend && (force_both || $urandom_range(0, 1) == 1)) begin
      d_pend = 1'b1;
      bus.data_we_i    = 1'($urandom);
      bus.data_be_i    = 4'($urandom);
      bus.data_addr_i  = 16'($urandom);
      bus.data_wdata_i = $urandom;
    end
    bus.instr_req_i = i_pend;
    bus.data_req_i  = d_pend;
    bus.mem_rdata_i = $urandom;
    step(do_chk);
    if (m_last == 1) i_pend = 1'b0;
    if (m_last == 2) d_pend = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    bus.mem_rdata_i  = '0;
    i_pend = 1'b0;
    d_pend = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    m_prio_d = 1'b1;
    m_rsp = 0;
    m_rsp_we = 1'b0;
    m_cnt = 0;
    m_last = 0;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    // requests during reset must be ignored
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    step(1);
    step(1);
    idle_inputs();
    rst = 1'b0;

    // single fetch
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = 16'h0010;
    #1;
    chk("f_gnt", bus.instr_gnt_o, 1'b1);
    chk("f_ce", bus.mem_ce_o, 1'b1);
    chk("f_we", bus.mem_we_o, 1'b0);
    step(1);
    idle_inputs();
    bus.mem_rdata_i = 32'hDEADBEEF;
    #1;
    chk("f_rv", bus.instr_rvalid_o, 1'b1);
    chk("f_rd", bus.instr_rdata_o, 32'hDEADBEEF);
    step(1);

    // contention right after reset: D,I,D,I
    do_reset();
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rdata_i = $urandom;
      #1;
      chk("seq_d", bus.data_gnt_o, (k % 2) == 0);
      chk("seq_i", bus.instr_gnt_o, (k % 2) == 1);
      step(1);
    end
    idle_inputs();
    bus.mem_rdata_i = 32'hA5A5_0001;
    #1;
    chk("seq_cnt", bus.conflict_cnt_o, 16'd4);
    chk("seq_irv", bus.instr_rvalid_o, 1'b1);
    step(1);

    // store
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_be_i    = 4'b0011;
    bus.data_addr_i  = 16'h0020;
    bus.data_wdata_i = 32'h12345678;
    #1;
    chk("st_we", bus.mem_we_o, 1'b1);
    chk("st_be", bus.mem_be_o, 4'b0011);
    chk("st_wd", bus.mem_wdata_o, 32'h12345678);
    step(1);
    idle_inputs();
    bus.mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    chk("st_rv", bus.data_rvalid_o, 1'b1);
    chk("st_rd", bus.data_rdata_o, 32'h0);
    step(1);

    // random traffic
    for (int k = 0; k < 3000; k++)
      rand_cycle(1'b0, 1'b1);

    // reset right after a data grant
    idle_inputs();
    bus.data_req_i = 1'b1;
    step(1);
    rst = 1'b1;
    bus.instr_req_i = 1'b1;
    #1;
    chk("rs_drv", bus.data_rvalid_o, 1'b0);
    chk("rs_gnt", bus.data_gnt_o | bus.instr_gnt_o, 1'b0);
    step(1);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rs_drv2", bus.data_rvalid_o, 1'b0);
    chk("rs_cnt", bus.conflict_cnt_o, 16'd0);
    step(1);
    bus.instr_req_i = 1'b1;
    bus.data_req_i  = 1'b1;
    #1;
    chk("rs_prio", bus.data_gnt_o, 1'b1);
    step(1);
    idle_inputs();

    // saturation under sustained contention
    for (int k = 0; k < 70000; k++)
      rand_cycle(1'b1, (k % 4096) == 0);
    idle_inputs();
    #1;
    chk("sat_cnt", bus.conflict_cnt_o, 16'hFFFF);
    step(1);

    for (int k = 0; k < 200; k++)
      rand_cycle(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/coremem_arbiter.md
COREMEM_ARBITER -- requirements
Module: coremem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, word-address width of the shared memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have ports, one per line, as follows (clock and reset first):
- clk_i  in  1  single clock; all state updates on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_req_i  in  1  instruction-fetch request (read only).
- instr_addr_i  in  ADDR_WIDTH  fetch word address.
- instr_gnt_o  out  1  fetch request accepted this cycle.
- instr_rvalid_o  out  1  fetch data valid.
- instr_rdata_o  out  DATA_WIDTH  fetch data.
- data_req_i  in  1  load/store request.
- data_we_i  in  1  1 = store, 0 = load.
- data_be_i  in  DATA_WIDTH/8  store byte enables.
- data_addr_i  in  ADDR_WIDTH  load/store word address.
- data_wdata_i  in  DATA_WIDTH  store data.
- data_gnt_o  out  1  load/store accepted this cycle.
- data_rvalid_o  out  1  load data valid / store complete.
- data_rdata_o  out  DATA_WIDTH  load data.
- mem_ce_o  out  1  single-port SRAM chip enable.
- mem_we_o  out  1  SRAM write enable.
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- mem_addr_o  out  ADDR_WIDTH  SRAM address.
- mem_wdata_o  out  DATA_WIDTH  SRAM write data.
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after mem_ce_o.
- conflict_cnt_o  out  16  saturating count of contended cycles.

Function
REQ-004 SHALL grant at most one requester per cycle; gnt combinational from req and priority state, same cycle as req.
REQ-005 SHALL accept a new grant every cycle (fully pipelined, no bubble between back-to-back grants).
REQ-006 With one request: that requester SHALL be granted.
REQ-007 With both requests: requester named by prio register SHALL win; loser sees gnt=0 and must hold req and payload.
REQ-008 prio register: after any grant SHALL point to the non-granted side; unchanged when no grant; reset value = DATA.
REQ-009 When granted, mem_ce_o SHALL be 1 and mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o SHALL carry the winner's fields same cycle.
REQ-010 Instruction grant SHALL drive mem_we_o=0, mem_be_o=all ones, mem_wdata_o=0.
REQ-011 No grant: mem_ce_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-012 Response FSM states IDLE, INSTR_RSP, DATA_RSP; next state = INSTR_RSP on instr grant, DATA_RSP on data grant, else IDLE.
REQ-013 In INSTR_RSP: instr_rvalid_o=1, instr_rdata_o=mem_rdata_i; data_rvalid_o=0, data_rdata_o=0.
REQ-014 In DATA_RSP: data_rvalid_o=1; data_rdata_o=mem_rdata_i for loads, 0 for stores (registered we); instr outputs 0.
REQ-015 In IDLE: both rvalid=0, both rdata=0.
REQ-016 Response latency SHALL be exactly one cycle after gnt; rvalid for grant N and gnt for grant N+1 may coincide.
REQ-017 conflict_cnt_o SHALL increment by 1 each cycle both req are high, saturating at 16'hFFFF (no wrap).
REQ-018 Invalid FSM encoding SHALL return to IDLE next cycle with no rvalid.

Reset
REQ-019 While rst_i=1: FSM=IDLE, prio=DATA, conflict_cnt_o=0, all rvalid/gnt/mem_* outputs 0, regardless of req.
REQ-020 Assertion mid-transaction SHALL drop any pending rvalid; first cycle after release behaves as from IDLE.

Verification
REQ-021 Only instr_req_i=1, addr=0x0010, mem_rdata_i=0xDEADBEEF next cycle -> instr_gnt_o=1, mem_ce_o=1, mem_we_o=0; next cycle instr_rvalid_o=1, instr_rdata_o=0xDEADBEEF.
REQ-022 Both req held 4 cycles after reset -> grants D,I,D,I; conflict_cnt_o=4; each rvalid one cycle after its gnt.
REQ-023 Store addr=0x0020, be=4'b0011, wdata=0x12345678 -> mem_we_o=1, mem_be_o=4'b0011, mem_wdata_o=0x12345678; next cycle data_rvalid_o=1, data_rdata_o=0.
REQ-024 Both req held 70000 cycles -> conflict_cnt_o stops at 0xFFFF.
REQ-025 rst_i pulsed the cycle after a data grant -> no data_rvalid_o, prio=DATA, conflict_cnt_o=0 after release.
